// File: rtl/expansion_stage.sv
// Parametrised E-expansion with optional subkey XOR, feeding a 2-entry elastic
// output buffer with valid/ready handshake and a saturating transfer counter.
module expansion_stage #(
    parameter int CHUNKS  = 8,
    parameter int CHUNK_W = 4,
    parameter int EDGE    = 1,
    parameter int KEY_XOR = 1,
    parameter int CNT_W   = 16,
    localparam int IN_W   = CHUNKS * CHUNK_W,
    localparam int OUT_W  = CHUNKS * (CHUNK_W + 2 * EDGE)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W:1]    in_data,
    input  logic [OUT_W:1]   in_key,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W:1]   out_data,
    output logic [CNT_W-1:0] xfer_count
);

    localparam int SEG_W = CHUNK_W + 2 * EDGE;

    if (EDGE < 0 || EDGE > CHUNK_W || CHUNKS <= 0 || CHUNK_W <= 0 || CNT_W <= 0) begin : g_bad_params
        $error("expansion_stage: illegal parameter combination");
    end

    logic [OUT_W:1]   expanded_s;
    logic [OUT_W:1]   result_s;
    logic [1:0]       count_r;
    logic [1:0]       count_s;
    logic [OUT_W:1]   head_r;
    logic [OUT_W:1]   head_s;
    logic [OUT_W:1]   tail_r;
    logic [OUT_W:1]   tail_s;
    logic             in_ready_r;
    logic             out_valid_r;
    logic [CNT_W-1:0] xfer_r;
    logic [CNT_W-1:0] xfer_s;
    logic             accept_s;
    logic             pop_s;

    // Each output bit taps one input bit; IN_W is added first so the modulo never sees a negative index.
    for (genvar j = 0; j < CHUNKS; j++) begin : g_chunk
        for (genvar k = 0; k < SEG_W; k++) begin : g_bit
            localparam int SRC = ((j * CHUNK_W + k - EDGE + IN_W) % IN_W) + 1;
            assign expanded_s[j * SEG_W + k + 1] = in_data[SRC];
        end
    end

    if (KEY_XOR != 0) begin : g_key
        assign result_s = expanded_s ^ in_key;
    end else begin : g_nokey
        assign result_s = expanded_s;
    end

    assign accept_s = in_valid & in_ready_r;
    assign pop_s    = out_valid_r & out_ready;

    // Next-state of the 2-entry buffer (head = oldest) and the transfer counter.
    always_comb begin
        count_s = count_r;
        head_s  = head_r;
        tail_s  = tail_r;
        xfer_s  = xfer_r;
        if (flush) begin
            count_s = 2'd0;
        end else begin
            case (count_r)
                2'd0: begin
                    if (accept_s) begin
                        head_s  = result_s;
                        count_s = 2'd1;
                    end else begin
                        count_s = 2'd0;
                    end
                end
                2'd1: begin
                    if (accept_s && pop_s) begin
                        head_s = result_s;
                    end else if (accept_s) begin
                        tail_s  = result_s;
                        count_s = 2'd2;
                    end else if (pop_s) begin
                        count_s = 2'd0;
                    end else begin
                        count_s = 2'd1;
                    end
                end
                2'd2: begin
                    if (pop_s) begin
                        head_s  = tail_r;
                        count_s = 2'd1;
                    end else begin
                        count_s = 2'd2;
                    end
                end
                default: begin
                    count_s = 2'd0;
                end
            endcase
            if (pop_s && (xfer_r != {CNT_W{1'b1}})) begin
                xfer_s = xfer_r + CNT_W'(1);
            end else begin
                xfer_s = xfer_r;
            end
        end
    end

    // State registers; handshake flags are precomputed from the next count so they leave the block registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r     <= 2'd0;
            head_r      <= '0;
            tail_r      <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            xfer_r      <= '0;
        end else begin
            count_r     <= count_s;
            head_r      <= head_s;
            tail_r      <= tail_s;
            in_ready_r  <= (count_s != 2'd2);
            out_valid_r <= (count_s != 2'd0);
            xfer_r      <= xfer_s;
        end
    end

    assign in_ready   = in_ready_r;
    assign out_valid  = out_valid_r;
    assign out_data   = head_r;
    assign xfer_count = xfer_r;

endmodule

// File: tb/tb_expansion_stage.sv
// Bench for expansion_stage: default DES configuration against the DES E table
// plus a queue model, and a widened no-key configuration against the index rule.
module tb_expansion_stage;

    localparam int E_TBL [0:47] = '{32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9,
                                     8, 9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
                                     16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
                                     24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32, 1};

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [32:1] in_data = '0;
    logic [48:1] in_key = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [48:1] out_data;
    logic [15:0] xfer_count;

    logic        g_flush = 1'b0;
    logic        g_in_valid = 1'b0;
    logic        g_in_ready;
    logic [32:1] g_in_data = '0;
    logic [48:1] g_in_key = '0;
    logic        g_out_valid;
    logic        g_out_ready = 1'b0;
    logic [48:1] g_out_data;
    logic [1:0]  g_xfer_count;

    int compared = 0;
    int mismatched = 0;
    logic [48:1] q[$];
    int xm = 0;

    always #5 clk = ~clk;

    expansion_stage dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_key(in_key),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .xfer_count(xfer_count)
    );

    expansion_stage #(.CHUNKS(4), .CHUNK_W(8), .EDGE(2), .KEY_XOR(0), .CNT_W(2)) dut_gen (
        .clk(clk), .reset(reset), .flush(g_flush),
        .in_valid(g_in_valid), .in_ready(g_in_ready), .in_data(g_in_data), .in_key(g_in_key),
        .out_valid(g_out_valid), .out_ready(g_out_ready), .out_data(g_out_data),
        .xfer_count(g_xfer_count)
    );

    function automatic logic [48:1] des_e(input logic [32:1] d);
        logic [48:1] e;
        for (int i = 1; i <= 48; i++) e[i] = d[E_TBL[i-1]];
        return e;
    endfunction

    function automatic logic [48:1] gen_e(input logic [32:1] d);
        logic [48:1] e;
        for (int j = 0; j < 4; j++)
            for (int k = 0; k < 12; k++)
                e[j*12 + k + 1] = d[(((j*8 + k - 2) % 32) + 32) % 32 + 1];
        return e;
    endfunction

    function automatic logic [48:1] rnd48();
        logic [63:0] w;
        w = {$urandom(), $urandom()};
        return w[47:0];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
        chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
        if (q.size() != 0) chk("out_data", 64'(out_data), 64'(q[0]));
        chk("xfer_count", 64'(xfer_count), 64'(xm));
    endtask

    task automatic cyc(input logic v, input logic [32:1] d, input logic [48:1] k,
                       input logic r, input logic f);
        logic acc;
        logic pop;
        in_valid = v; in_data = d; in_key = k; out_ready = r; flush = f;
        acc = v && (q.size() < 2);
        pop = r && (q.size() > 0);
        @(posedge clk); #1;
        if (f) begin
            q.delete();
        end else begin
            if (pop) begin
                q.delete(0);
                if (xm < 65535) xm++;
            end
            if (acc) q.push_back(des_e(d) ^ k);
        end
        in_valid = 1'b0; flush = 1'b0;
        check_all();
    endtask

    task automatic do_reset();
        reset = 1'b1; in_valid = 1'b0; flush = 1'b0; g_in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        q.delete();
        xm = 0;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_xfer", 64'(xfer_count), 64'd0);
        chk("rst_gen_xfer", 64'(g_xfer_count), 64'd0);
    endtask

    initial begin
        logic [32:1] d;
        logic [32:1] base;
        logic [48:1] k;
        int saved;

        do_reset();

        // Basic expansions against literal values
        cyc(1'b1, 32'h00000001, 48'h0, 1'b1, 1'b0);
        chk("tp_one", 64'(out_data), 64'h800000000002);
        cyc(1'b1, 32'h80000000, 48'h0, 1'b1, 1'b0);
        chk("tp_msb", 64'(out_data), 64'h400000000001);
        cyc(1'b1, 32'hFFFFFFFF, 48'hFFFFFFFFFFFF, 1'b1, 1'b0);
        chk("tp_ones_key", 64'(out_data), 64'h0);
        cyc(1'b0, 32'h0, 48'h0, 1'b1, 1'b0);

        // Backpressure: fill both entries, hold, then drain in order
        do_reset();
        cyc(1'b1, 32'h00000001, 48'h0, 1'b0, 1'b0);
        cyc(1'b1, 32'h80000000, 48'h0, 1'b0, 1'b0);
        chk("bp_full_ready", 64'(in_ready), 64'd0);
        cyc(1'b1, 32'hDEADBEEF, 48'h0, 1'b0, 1'b0);
        chk("bp_hold", 64'(out_data), 64'h800000000002);
        cyc(1'b0, 32'h0, 48'h0, 1'b1, 1'b0);
        chk("bp_second", 64'(out_data), 64'h400000000001);
        cyc(1'b0, 32'h0, 48'h0, 1'b1, 1'b0);
        chk("bp_xfer", 64'(xfer_count), 64'd2);

        // Streaming 100 words, no bubbles
        do_reset();
        base = $urandom();
        for (int i = 0; i < 100; i++) begin
            k = rnd48();
            cyc(1'b1, base + 32'(i), k, 1'b1, 1'b0);
            chk("stream_valid", 64'(out_valid), 64'd1);
        end
        cyc(1'b0, 32'h0, 48'h0, 1'b1, 1'b0);
        chk("stream_xfer", 64'(xfer_count), 64'd100);

        // Randomised handshake traffic with occasional flushes
        for (int i = 0; i < 300; i++) begin
            d = $urandom();
            k = rnd48();
            cyc(1'($urandom_range(0, 1)), d, k, 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 15) == 0));
        end

        // Flush with two entries plus a simultaneous push and pop
        cyc(1'b0, 32'h0, 48'h0, 1'b1, 1'b0);
        cyc(1'b0, 32'h0, 48'h0, 1'b1, 1'b0);
        cyc(1'b1, $urandom(), rnd48(), 1'b0, 1'b0);
        cyc(1'b1, $urandom(), rnd48(), 1'b0, 1'b0);
        saved = xm;
        cyc(1'b1, $urandom(), rnd48(), 1'b1, 1'b1);
        chk("flush_valid", 64'(out_valid), 64'd0);
        chk("flush_ready", 64'(in_ready), 64'd1);
        chk("flush_xfer", 64'(xfer_count), 64'(saved));

        // Reset with one entry buffered
        cyc(1'b1, $urandom(), rnd48(), 1'b0, 1'b0);
        do_reset();

        // Widened no-key configuration and counter saturation
        g_out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            d = $urandom();
            g_in_valid = 1'b1; g_in_data = d; g_in_key = rnd48();
            @(posedge clk); #1;
            g_in_valid = 1'b0;
            chk("gen_valid", 64'(g_out_valid), 64'd1);
            chk("gen_data", 64'(g_out_data), 64'(gen_e(d)));
            chk("gen_b1", 64'(g_out_data[1]), 64'(d[31]));
            chk("gen_b2", 64'(g_out_data[2]), 64'(d[32]));
            chk("gen_b47", 64'(g_out_data[47]), 64'(d[1]));
            chk("gen_b48", 64'(g_out_data[48]), 64'(d[2]));
            @(posedge clk); #1;
            chk("gen_xfer", 64'(g_xfer_count), 64'((i + 1 < 3) ? i + 1 : 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
